rect_fill_engine: RTL and testbench



---
 rtl/rect_fill_engine.sv | 118 +++++++++++
 tb/tb_rect_fill_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// Rectangle rasterizer: walks a clipped box one pixel per enabled clock and drives the VGA plot strobe.
// Latency: first pixel one cycle after the latch edge, then one pixel per enabled cycle; done one cycle after the last pixel.
// Backpressure: iEnable low freezes everything and masks oPlot/oDone; iReq low mid-draw aborts to IDLE without done.
module rect_fill_engine #(
  parameter int X_SCREEN_PIXELS = 320,
  parameter int Y_SCREEN_PIXELS = 240,
  localparam int XW = $clog2(X_SCREEN_PIXELS) + 1,
  localparam int YW = $clog2(Y_SCREEN_PIXELS) + 1
) (
  input  logic          iClock,
  input  logic          iResetn,
  input  logic          iEnable,
  input  logic          iReq,
  input  logic [XW-1:0] iX0,
  input  logic [YW-1:0] iY0,
  input  logic [XW-1:0] iWidth,
  input  logic [YW-1:0] iHeight,
  input  logic [2:0]    iColour,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic [2:0]    oColour,
  output logic          oPlot,
  output logic          oBusy,
  output logic          oDone
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE, HOLD} state_t;

  localparam logic [XW-1:0] X_MAX = XW'(X_SCREEN_PIXELS);
  localparam logic [YW-1:0] Y_MAX = YW'(Y_SCREEN_PIXELS);

  state_t        state_q, state_d;
  logic [XW-1:0] x0_q, w_q, cx_q;
  logic [YW-1:0] y0_q, h_q, cy_q;
  logic [2:0]    col_q;

  // Origin range check comes first; the remaining-span subtraction is only
  // meaningful (non-wrapping) when the origin is on screen.
  logic          x_oob, y_oob, empty;
  logic [XW-1:0] rem_x, clip_w;
  logic [YW-1:0] rem_y, clip_h;
  logic          last_col, last_row;

  assign x_oob    = (iX0 >= X_MAX);
  assign y_oob    = (iY0 >= Y_MAX);
  assign rem_x    = X_MAX - iX0;
  assign rem_y    = Y_MAX - iY0;
  assign clip_w   = (iWidth < rem_x) ? iWidth : rem_x;
  assign clip_h   = (iHeight < rem_y) ? iHeight : rem_y;
  assign empty    = x_oob || y_oob || (clip_w == '0) || (clip_h == '0);
  assign last_col = (cx_q == w_q - XW'(1));
  assign last_row = (cy_q == h_q - YW'(1));

  // Next-state decode; abort on a dropped request takes priority over completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iReq) state_d = empty ? DONE : DRAW;
      DRAW: begin
        if (!iReq)                    state_d = IDLE;
        else if (last_col && last_row) state_d = DONE;
      end
      DONE:    state_d = iReq ? HOLD : IDLE;
      HOLD:    if (!iReq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; only enabled edges move the FSM.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn)     state_q <= IDLE;
    else if (iEnable) state_q <= state_d;
  end

  // Capture origin, colour and clipped size on the accepting edge; later operand changes are ignored.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      x0_q  <= '0;
      y0_q  <= '0;
      w_q   <= '0;
      h_q   <= '0;
      col_q <= '0;
    end else if (iEnable && (state_q == IDLE) && iReq) begin
      x0_q  <= iX0;
      y0_q  <= iY0;
      w_q   <= clip_w;
      h_q   <= clip_h;
      col_q <= iColour;
    end
  end

  // Raster counters, X fastest; held at zero outside DRAW so every draw starts at the origin.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (iEnable) begin
      if (state_q != DRAW) begin
        cx_q <= '0;
        cy_q <= '0;
      end else if (last_col) begin
        cx_q <= '0;
        cy_q <= cy_q + YW'(1);
      end else begin
        cx_q <= cx_q + XW'(1);
      end
    end
  end

  // Outputs are decodes of registered state; strobes are masked while frozen.
  assign oX      = x0_q + cx_q;
  assign oY      = y0_q + cy_q;
  assign oColour = col_q;
  assign oBusy   = (state_q == DRAW);
  assign oPlot   = (state_q == DRAW) && iEnable;
  assign oDone   = (state_q == DONE) && iEnable;

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

  logic       iClock = 1'b0;
  logic       iResetn;
  logic       iEnable;
  logic       iReq;
  logic [9:0] iX0;
  logic [8:0] iY0;
  logic [9:0] iWidth;
  logic [8:0] iHeight;
  logic [2:0] iColour;
  logic [9:0] oX;
  logic [8:0] oY;
  logic [2:0] oColour;
  logic       oPlot;
  logic       oBusy;
  logic       oDone;

  rect_fill_engine #(.X_SCREEN_PIXELS(320), .Y_SCREEN_PIXELS(240)) dut (
    .iClock  (iClock),
    .iResetn (iResetn),
    .iEnable (iEnable),
    .iReq    (iReq),
    .iX0     (iX0),
    .iY0     (iY0),
    .iWidth  (iWidth),
    .iHeight (iHeight),
    .iColour (iColour),
    .oX      (oX),
    .oY      (oY),
    .oColour (oColour),
    .oPlot   (oPlot),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  always #5 iClock = ~iClock;

  int n_assert = 0;
  int n_fail   = 0;

  // Observation record for the current draw; cycle 0 is the cycle in which the request is raised.
  int cyc, n_plot, first_plot, last_plot, done_cnt, done_at, last_x, last_y;
  int px_x[$];
  int px_y[$];
  int px_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = -1; n_plot = 0; first_plot = -1; last_plot = -1;
    done_cnt = 0; done_at = -1; last_x = -1; last_y = -1;
    px_x.delete(); px_y.delete(); px_c.delete();
  endtask

  // Step to just after the next rising edge; inputs changed here belong to the new cycle.
  task automatic drive_edge();
    @(posedge iClock);
    #1;
  endtask

  // Sample n cycles at the falling edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iClock);
      cyc++;
      if (oPlot) begin
        n_plot++;
        if (first_plot < 0) first_plot = cyc;
        last_plot = cyc;
        last_x = int'(oX);
        last_y = int'(oY);
        if (px_x.size() < 64) begin
          px_x.push_back(int'(oX));
          px_y.push_back(int'(oY));
          px_c.push_back(int'(oColour));
        end
      end
      if (oDone) begin
        done_cnt++;
        done_at = cyc;
      end
    end
  endtask

  task automatic req(input int x0, input int y0, input int w, input int h, input int c);
    drive_edge();
    iX0 = 10'(x0); iY0 = 9'(y0); iWidth = 10'(w); iHeight = 9'(h); iColour = 3'(c);
    iReq = 1'b1;
    clr();
  endtask

  task automatic drop();
    drive_edge();
    iReq = 1'b0;
    run(2);
  endtask

  initial begin
    iResetn = 1'b1; iEnable = 1'b0; iReq = 1'b0;
    iX0 = '0; iY0 = '0; iWidth = '0; iHeight = '0; iColour = '0;
    clr();
    #2 iResetn = 1'b0;

    // Reset state
    @(negedge iClock);
    chk("rst_x", 32'(oX), 0);
    chk("rst_y", 32'(oY), 0);
    chk("rst_col", 32'(oColour), 0);
    chk("rst_plot", 32'(oPlot), 0);
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_done", 32'(oDone), 0);
    drive_edge();
    iResetn = 1'b1; iEnable = 1'b1;
    clr();
    run(2);
    chk("idle_plot", 32'(n_plot), 0);

    // 4x4 box at (10,20) colour 3, operands scrambled after the latch edge
    req(10, 20, 4, 4, 3);
    run(2);
    drive_edge();
    iX0 = 10'd100; iY0 = 9'd5; iColour = 3'd5; iWidth = 10'd1;
    run(19);
    chk("box_nplot", 32'(n_plot), 16);
    chk("box_first_cyc", 32'(first_plot), 1);
    chk("box_last_cyc", 32'(last_plot), 16);
    chk("box_p0_x", 32'(px_x[0]), 10);
    chk("box_p0_y", 32'(px_y[0]), 20);
    chk("box_p0_c", 32'(px_c[0]), 3);
    chk("box_p4_x", 32'(px_x[4]), 10);
    chk("box_p4_y", 32'(px_y[4]), 21);
    chk("box_p15_x", 32'(px_x[15]), 13);
    chk("box_p15_y", 32'(px_y[15]), 23);
    chk("box_p15_c", 32'(px_c[15]), 3);
    chk("box_done_at", 32'(done_at), 17);
    chk("box_done_cnt", 32'(done_cnt), 1);
    chk("box_hold_busy", 32'(oBusy), 0);
    drop();

    // Clipping at the bottom-right corner
    req(318, 238, 5, 4, 7);
    run(8);
    chk("clip_nplot", 32'(n_plot), 4);
    chk("clip_p0", 32'(px_x[0] * 1000 + px_y[0]), 318238);
    chk("clip_p1", 32'(px_x[1] * 1000 + px_y[1]), 319238);
    chk("clip_p2", 32'(px_x[2] * 1000 + px_y[2]), 318239);
    chk("clip_p3", 32'(px_x[3] * 1000 + px_y[3]), 319239);
    chk("clip_col", 32'(px_c[3]), 7);
    chk("clip_done_at", 32'(done_at), 5);
    drop();

    // Origin off screen
    req(320, 0, 4, 4, 1);
    run(4);
    chk("oob_nplot", 32'(n_plot), 0);
    chk("oob_done_at", 32'(done_at), 1);
    chk("oob_done_cnt", 32'(done_cnt), 1);
    drop();

    // Zero width
    req(5, 5, 0, 8, 2);
    run(4);
    chk("zero_nplot", 32'(n_plot), 0);
    chk("zero_done_at", 32'(done_at), 1);
    drop();

    // Done deferred while disabled
    req(320, 0, 4, 4, 1);
    run(1);
    drive_edge();
    iEnable = 1'b0;
    run(3);
    chk("defer_no_done", 32'(done_cnt), 0);
    drive_edge();
    iEnable = 1'b1;
    run(2);
    chk("defer_done_at", 32'(done_at), 4);
    chk("defer_done_cnt", 32'(done_cnt), 1);
    drop();

    // Abort a clipped 40x5 paddle at (315,100) after 5 plots
    req(315, 100, 40, 5, 2);
    run(5);
    drive_edge();
    iReq = 1'b0;
    run(5);
    chk("abort_nplot", 32'(n_plot), 5);
    chk("abort_last_cyc", 32'(last_plot), 5);
    chk("abort_p4", 32'(px_x[4] * 1000 + px_y[4]), 319100);
    chk("abort_no_done", 32'(done_cnt), 0);
    chk("abort_busy", 32'(oBusy), 0);
    drive_edge();
    iReq = 1'b1;
    clr();
    run(3);
    chk("restart_first_cyc", 32'(first_plot), 1);
    chk("restart_p0", 32'(px_x[0] * 1000 + px_y[0]), 315100);
    drop();

    // Pause for 7 cycles after 3 plots of a 4x4 box
    req(10, 20, 4, 4, 3);
    run(4);
    drive_edge();
    iEnable = 1'b0; iX0 = 10'd200; iColour = 3'd6;
    run(7);
    chk("pause_nplot", 32'(n_plot), 3);
    chk("pause_busy", 32'(oBusy), 1);
    chk("pause_no_done", 32'(done_cnt), 0);
    drive_edge();
    iEnable = 1'b1;
    run(20);
    chk("pause_total", 32'(n_plot), 16);
    chk("pause_p3", 32'(px_x[3] * 1000 + px_y[3]), 13020);
    chk("pause_p4", 32'(px_x[4] * 1000 + px_y[4]), 10021);
    chk("pause_p15", 32'(px_x[15] * 1000 + px_y[15]), 13023);
    chk("pause_resume_cyc", 32'(last_plot), 23);
    chk("pause_done_at", 32'(done_at), 24);
    chk("pause_done_cnt", 32'(done_cnt), 1);
    drop();

    // Full-screen black
    req(0, 0, 320, 240, 0);
    run(76803);
    chk("full_nplot", 32'(n_plot), 76800);
    chk("full_last_x", 32'(last_x), 319);
    chk("full_last_y", 32'(last_y), 239);
    chk("full_done_at", 32'(done_at), 76801);
    chk("full_done_cnt", 32'(done_cnt), 1);
    drop();

    // Reset asserted while plotting pixel 1000
    req(0, 0, 320, 240, 0);
    iColour = 3'd5;
    run(1000);
    drive_edge();
    chk("mid_plot_before", 32'(oPlot), 1);
    iResetn = 1'b0;
    #1;
    chk("mid_rst_x", 32'(oX), 0);
    chk("mid_rst_y", 32'(oY), 0);
    chk("mid_rst_col", 32'(oColour), 0);
    chk("mid_rst_plot", 32'(oPlot), 0);
    chk("mid_rst_busy", 32'(oBusy), 0);
    chk("mid_rst_done", 32'(oDone), 0);
    iReq = 1'b0;
    run(3);
    iResetn = 1'b1;
    run(3);
    chk("mid_nplot", 32'(n_plot), 999);
    chk("mid_no_done", 32'(done_cnt), 0);
    chk("mid_idle_busy", 32'(oBusy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
